// File: rtl/calc_pkg.sv
// Shared definitions for the calculator BCD/binary converters.
package calc_pkg;

    // Operand geometry shared with the binary-to-BCD display converter
    localparam int unsigned BCD_DIGITS = 5;
    localparam int unsigned BIN_W      = 16;

    // Converter control states
    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    // A packed-BCD nibble is illegal when it encodes a value above 9
    function automatic logic bcd_bad(input logic [3:0] digit);
        return digit > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_mac10.sv
// Combinational multiply-by-ten-and-add step for BCD-to-binary conversion.
module bcd_mac10 #(
    parameter int unsigned ACC_W = 17
) (
    input  logic [ACC_W-1:0] acc_in,
    input  logic [3:0]       digit,
    output logic [ACC_W-1:0] acc_out,
    output logic             bad
);
    import calc_pkg::bcd_bad;

    // acc*10 + digit as shift-and-add; wrap is harmless since bad digits force err
    always_comb begin
        acc_out = (acc_in << 3) + (acc_in << 1) + {{(ACC_W-4){1'b0}}, digit};
        bad     = bcd_bad(digit);
    end

endmodule

// File: rtl/bcd2bin.sv
// Iterative packed-BCD to binary converter, one digit per clock, MSD first.
module bcd2bin #(
    parameter int unsigned DIGITS = calc_pkg::BCD_DIGITS,
    parameter int unsigned BIN_W  = calc_pkg::BIN_W
) (
    input  logic                  sclk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   data_i,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      data_o,
    output logic                  ovf,
    output logic                  err
);
    import calc_pkg::state_t;
    import calc_pkg::IDLE;
    import calc_pkg::CALC;

    // Accumulator is just wide enough for the largest decimal operand
    localparam int unsigned      ACC_W   = $clog2(10 ** DIGITS);
    localparam int unsigned      CNT_W   = $clog2(DIGITS + 1);
    localparam logic [ACC_W-1:0] BIN_MAX = ACC_W'((64'd1 << BIN_W) - 64'd1);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(DIGITS - 1);

    state_t              state_q;
    logic [4*DIGITS-1:0] shreg_q;
    logic [ACC_W-1:0]    acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                bad_q;

    logic [ACC_W-1:0]    acc_nxt;
    logic                dig_bad;
    logic                bad_fin;

    bcd_mac10 #(
        .ACC_W (ACC_W)
    ) u_mac (
        .acc_in  (acc_q),
        .digit   (shreg_q[4*DIGITS-1 -: 4]),
        .acc_out (acc_nxt),
        .bad     (dig_bad)
    );

    // Sticky bad flag must include the digit being consumed on the final edge
    assign bad_fin = bad_q | dig_bad;

    // Control FSM, datapath state and registered result outputs
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bad_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            data_o  <= '0;
            ovf     <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shreg_q <= data_i;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        bad_q   <= 1'b0;
                        busy    <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    acc_q   <= acc_nxt;
                    shreg_q <= {shreg_q[4*DIGITS-5:0], 4'h0};
                    bad_q   <= bad_fin;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        if (bad_fin) begin
                            data_o <= '0;
                            err    <= 1'b1;
                            ovf    <= 1'b0;
                        end else if (acc_nxt > BIN_MAX) begin
                            data_o <= '1;
                            err    <= 1'b0;
                            ovf    <= 1'b1;
                        end else begin
                            data_o <= acc_nxt[BIN_W-1:0];
                            err    <= 1'b0;
                            ovf    <= 1'b0;
                        end
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd2bin.sv
// Scoreboard bench for bcd2bin: driver pushes expectations, monitor checks on done.
module tb_bcd2bin;

    logic        sclk;
    logic        rst_n;
    logic        start;
    logic [19:0] data_i;
    logic        busy;
    logic        done;
    logic [15:0] data_o;
    logic        ovf;
    logic        err;

    typedef struct {
        logic [15:0] data;
        logic        ovf;
        logic        err;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    bcd2bin dut (
        .sclk   (sclk),
        .rst_n  (rst_n),
        .start  (start),
        .data_i (data_i),
        .busy   (busy),
        .done   (done),
        .data_o (data_o),
        .ovf    (ovf),
        .err    (err)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    always @(posedge sclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge sclk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_data"}, 32'(data_o), 32'(e.data));
                check({e.name, "_ovf"},  32'(ovf),    32'(e.ovf));
                check({e.name, "_err"},  32'(err),    32'(e.err));
                check({e.name, "_cyc"},  32'(cyc),    32'(e.cyc));
                check({e.name, "_busy"}, 32'(busy),   32'd0);
            end
        end
    end

    // Start a conversion; expected done is 5 edges after the sampling edge
    task automatic issue(input string name, input logic [19:0] d, input logic [15:0] ed,
                         input logic eo, input logic ee);
        exp_t e;
        @(negedge sclk);
        start  = 1'b1;
        data_i = d;
        @(posedge sclk);
        #1;
        start  = 1'b0;
        e.data = ed; e.ovf = eo; e.err = ee; e.cyc = cyc + 5; e.name = name;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge sclk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        int   d1;
        exp_t e;
        rst_n  = 1'b0;
        start  = 1'b0;
        data_i = '0;
        #1;
        check("rst_busy", 32'(busy),   32'd0);
        check("rst_done", 32'(done),   32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_ovf",  32'(ovf),    32'd0);
        check("rst_err",  32'(err),    32'd0);
        repeat (2) @(negedge sclk);
        rst_n = 1'b1;

        // Basic conversion, busy high for the five digit cycles
        issue("c12345", 20'h12345, 16'h3039, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge sclk);
            check("c12345_busy_hi", 32'(busy), 32'd1);
        end
        drain();

        // Overflow boundary
        issue("c65535", 20'h65535, 16'hFFFF, 1'b0, 1'b0);
        drain();
        issue("c65536", 20'h65536, 16'hFFFF, 1'b1, 1'b0);
        drain();
        issue("c99999", 20'h99999, 16'hFFFF, 1'b1, 1'b0);
        drain();

        // Illegal digits, including one in the final position
        issue("c1A000", 20'h1A000, 16'h0000, 1'b0, 1'b1);
        drain();
        issue("c0000F", 20'h0000F, 16'h0000, 1'b0, 1'b1);
        drain();

        // start while busy is ignored; start in the done cycle is accepted
        issue("c00042", 20'h00042, 16'h002A, 1'b0, 1'b0);
        @(negedge sclk);
        start  = 1'b1;
        data_i = 20'h00007;
        @(negedge sclk);
        start  = 1'b0;
        data_i = 20'h00099;
        d1 = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge sclk);
            if (done) begin
                d1 = cyc;
                break;
            end
        end
        check("b2b_first_done", 32'(done), 32'd1);
        start  = 1'b1;
        data_i = 20'h00007;
        @(posedge sclk);
        #1;
        start  = 1'b0;
        e.data = 16'h0007; e.ovf = 1'b0; e.err = 1'b0; e.cyc = d1 + 6; e.name = "b2b_second";
        sb.push_back(e);
        drain();

        // Asynchronous reset mid-conversion aborts with no done
        issue("abort", 20'h54321, 16'h0000, 1'b0, 1'b0);
        void'(sb.pop_back());
        @(posedge sclk);
        @(posedge sclk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy),   32'd0);
        check("abort_done", 32'(done),   32'd0);
        check("abort_data", 32'(data_o), 32'd0);
        check("abort_ovf",  32'(ovf),    32'd0);
        check("abort_err",  32'(err),    32'd0);
        @(negedge sclk);
        @(negedge sclk);
        rst_n = 1'b1;
        repeat (8) @(negedge sclk);
        issue("c00010", 20'h00010, 16'h000A, 1'b0, 1'b0);
        drain();

        // Outputs hold while idle regardless of data_i
        for (int i = 0; i < 20; i++) begin
            @(negedge sclk);
            data_i = 20'($urandom);
            start  = 1'b0;
            @(negedge sclk);
            check("hold_data", 32'(data_o), 32'h000A);
            check("hold_ovf",  32'(ovf),    32'd0);
            check("hold_err",  32'(err),    32'd0);
            check("hold_done", 32'(done),   32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
